hazard_ctrl: RTL

//  Central pipeline sequencer for the 5-stage RV32I core. Detects load-use hazards, converts EX-stage redirects
//  (taken branch, jal, jalr) into flushes, freezes the pipe while data memory is busy, and watchdogs memory waits.

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/hz_sat_counter.sv | 31 +++
 rtl/hazard_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage RV32I core.
// Holds the hazard sequencer state encoding, the latched flush kind,
// the canonical nop encoding and the RV32I major opcodes used by decode.
package pipe_pkg;

    // Hazard sequencer states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2,
        ERROR    = 2'd3
    } hz_state_e;

    // Which flush line a redirect keeps re-asserting while in REDIRECT
    typedef enum logic {
        FLUSH_BRANCH = 1'b0,
        FLUSH_JAL    = 1'b1
    } flush_kind_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_OPIMM  = 7'b001_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

    // True when the IF/ID instruction reads the register a load in ID/EX writes.
    // x0 never creates a dependency.
    function automatic logic load_use_hit(
        input logic       ex_load,
        input logic [4:0] ex_rd,
        input logic [4:0] rs1,
        input logic       use_rs1,
        input logic [4:0] rs2,
        input logic       use_rs2
    );
        logic hit_s;
        hit_s = 1'b0;
        if (ex_load && (ex_rd != 5'd0)) begin
            hit_s = (use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd));
        end else begin
            hit_s = 1'b0;
        end
        return hit_s;
    endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// Saturating event counter.
// Ports: clk, rst (async, active-high), clr (sync clear), inc (count enable),
//        cnt (current value, sticks at all-ones).
module hz_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Count register: clear wins over increment, stop at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != {W{1'b1}})) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage RV32I core.
// Detects load-use hazards, turns EX redirects into flushes, freezes the pipe
// while dmem is busy and watchdogs long memory waits.
// Ports:
//   clk, rst                 clock, async active-high reset
//   id_rs1/id_rs2, id_use_*  sources of the IF/ID instruction
//   ex_load, ex_regD         load and destination in ID/EX
//   ex_br_taken/ex_jal/jalr  EX redirect requests
//   mem_req, mem_ready       dmem handshake of the MEM stage
//   stall, stall_if          decode hold / PC+IF/ID hold
//   bubble_id                ID/EX loads a nop at the next edge
//   jal_flush, branch_flush  squash IF/ID and ID/EX
//   freeze                   hold EX/MEM and MEM/WB
//   err                      sticky watchdog error
//   stall_cnt, flush_cnt     saturating performance counters
// All control outputs are Mealy and forced low while rst is high.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REDIRECT_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT     = 255,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_load,
    input  logic [4:0]       ex_regD,
    input  logic             ex_br_taken,
    input  logic             ex_jal,
    input  logic             ex_jalr,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall,
    output logic             stall_if,
    output logic             bubble_id,
    output logic             jal_flush,
    output logic             branch_flush,
    output logic             freeze,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [2:0] RC_L  = 3'(REDIRECT_CYCLES);
    localparam logic [7:0] MT_L  = 8'(MEM_TIMEOUT);
    localparam bit         WD_EN = (MEM_TIMEOUT != 0);

    hz_state_e   state_r, state_nxt_s;
    flush_kind_e kind_r, kind_nxt_s;
    logic [2:0]  rcnt_r, rcnt_nxt_s;
    logic [7:0]  wcnt_r, wcnt_nxt_s;

    logic mem_busy_s, redirect_s, load_use_s;
    logic stall_s, stall_if_s, bubble_s, jal_s, branch_s, freeze_s, err_s;
    logic flush_ev_s;
    logic stall_if_o_s, flush_ev_o_s;

    assign mem_busy_s = mem_req && !mem_ready;
    assign redirect_s = ex_br_taken || ex_jal || ex_jalr;
    assign load_use_s = load_use_hit(ex_load, ex_regD, id_rs1, id_use_rs1, id_rs2, id_use_rs2);

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RUN;
            kind_r  <= FLUSH_BRANCH;
            rcnt_r  <= 3'd0;
            wcnt_r  <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            kind_r  <= kind_nxt_s;
            rcnt_r  <= rcnt_nxt_s;
            wcnt_r  <= wcnt_nxt_s;
        end
    end

    // Next-state and Mealy control decode
    always_comb begin
        state_nxt_s = state_r;
        kind_nxt_s  = kind_r;
        rcnt_nxt_s  = rcnt_r;
        wcnt_nxt_s  = wcnt_r;
        stall_s     = 1'b0;
        stall_if_s  = 1'b0;
        bubble_s    = 1'b0;
        jal_s       = 1'b0;
        branch_s    = 1'b0;
        freeze_s    = 1'b0;
        err_s       = 1'b0;
        flush_ev_s  = 1'b0;

        case (state_r)
            RUN: begin
                if (mem_busy_s) begin
                    // EX is held, so redirect/load-use are seen again after release
                    stall_s     = 1'b1;
                    stall_if_s  = 1'b1;
                    freeze_s    = 1'b1;
                    wcnt_nxt_s  = 8'd1;
                    state_nxt_s = MEM_WAIT;
                end else if (redirect_s) begin
                    // Fetch keeps running so the target is loaded this edge
                    if (ex_br_taken) begin
                        branch_s   = 1'b1;
                        kind_nxt_s = FLUSH_BRANCH;
                    end else begin
                        jal_s      = 1'b1;
                        kind_nxt_s = FLUSH_JAL;
                    end
                    flush_ev_s = 1'b1;
                    if (RC_L != 3'd0) begin
                        rcnt_nxt_s  = RC_L;
                        state_nxt_s = REDIRECT;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else if (load_use_s) begin
                    // Decode advances into a nop; the dependent instruction waits one cycle
                    stall_if_s = 1'b1;
                    bubble_s   = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end

            MEM_WAIT: begin
                if (wcnt_r != 8'hFF) begin
                    wcnt_nxt_s = wcnt_r + 8'd1;
                end else begin
                    wcnt_nxt_s = wcnt_r;
                end
                if (mem_ready) begin
                    // Release cycle: every control low so the pipe advances
                    state_nxt_s = RUN;
                end else if (WD_EN && (wcnt_r == MT_L)) begin
                    stall_s     = 1'b1;
                    stall_if_s  = 1'b1;
                    freeze_s    = 1'b1;
                    state_nxt_s = ERROR;
                end else begin
                    stall_s     = 1'b1;
                    stall_if_s  = 1'b1;
                    freeze_s    = 1'b1;
                    state_nxt_s = MEM_WAIT;
                end
            end

            REDIRECT: begin
                // EX holds nops here, so ex_* is not looked at
                branch_s = (kind_r == FLUSH_BRANCH);
                jal_s    = (kind_r == FLUSH_JAL);
                if (mem_busy_s) begin
                    stall_s    = 1'b1;
                    stall_if_s = 1'b1;
                    freeze_s   = 1'b1;
                    rcnt_nxt_s = rcnt_r;
                end else if (rcnt_r <= 3'd1) begin
                    rcnt_nxt_s  = 3'd0;
                    state_nxt_s = RUN;
                end else begin
                    rcnt_nxt_s = rcnt_r - 3'd1;
                end
            end

            ERROR: begin
                stall_s    = 1'b1;
                stall_if_s = 1'b1;
                freeze_s   = 1'b1;
                err_s      = 1'b1;
            end

            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // Reset masks every combinational control
    assign stall        = stall_s    & ~rst;
    assign stall_if_o_s = stall_if_s & ~rst;
    assign stall_if     = stall_if_o_s;
    assign bubble_id    = bubble_s   & ~rst;
    assign jal_flush    = jal_s      & ~rst;
    assign branch_flush = branch_s   & ~rst;
    assign freeze       = freeze_s   & ~rst;
    assign err          = err_s      & ~rst;
    assign flush_ev_o_s = flush_ev_s & ~rst;

    hz_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (stall_if_o_s),
        .cnt (stall_cnt)
    );

    hz_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (flush_ev_o_s),
        .cnt (flush_cnt)
    );

endmodule
